// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: Wishbone bundle between N_MASTER requesters, the round-robin arbiter and one slave.
interface wb_rr_arbiter_if #(
    parameter int N_MASTER = 4,
    parameter int TAGSIZE  = 1
);
    logic [N_MASTER-1:0]         m_cyc_i;
    logic [N_MASTER-1:0]         m_stb_i;
    logic [N_MASTER-1:0]         m_we_i;
    logic [4*N_MASTER-1:0]       m_sel_i;
    logic [32*N_MASTER-1:0]      m_adr_i;
    logic [32*N_MASTER-1:0]      m_dat_i;
    logic [TAGSIZE*N_MASTER-1:0] m_tgd_i;
    logic [31:0]                 m_dat_o;
    logic [N_MASTER-1:0]         m_ack_o;
    logic [N_MASTER-1:0]         m_err_o;
    logic                        s_cyc_o;
    logic                        s_stb_o;
    logic                        s_we_o;
    logic [3:0]                  s_sel_o;
    logic [31:0]                 s_adr_o;
    logic [31:0]                 s_dat_o;
    logic [TAGSIZE-1:0]          s_tgd_o;
    logic [31:0]                 s_dat_i;
    logic                        s_ack_i;
    logic                        s_err_i;

    // The arbiter is the slave of the masters; the environment drives the masters and models the slave.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_tgd_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_tgd_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_tgd_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_tgd_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: CYC-locked round-robin Wishbone arbiter, N_MASTER requesters onto one slave.
// Define WB_ARB_TIMEOUT_EN to add a stalled-slave watchdog that errors the master and aborts the cycle.
module wb_rr_arbiter #(
    parameter int N_MASTER       = 4,
    parameter int TAGSIZE        = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rstn_i,
    wb_rr_arbiter_if.slave      bus,
    output logic [N_MASTER-1:0] grant_o,
    output logic                busy_o
);
    localparam int LW = $clog2(N_MASTER);

    if (N_MASTER < 2 || N_MASTER > 8 || TAGSIZE < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("wb_rr_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT
`ifdef WB_ARB_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] gidx_q, gidx_d;
    logic [LW-1:0] pick, idx;
    logic          found;

    assign busy_o  = state_q != IDLE;
    assign grant_o = busy_o ? N_MASTER'(1) << gidx_q : '0;

    // First requester after the last served master, wrapping around.
    always_comb begin
        pick  = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_MASTER; i++) begin
            idx = LW'((int'(last_q) + i) % N_MASTER);
            if (!found && bus.m_cyc_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;
    assign tmo   = state_q == GRANT && cnt_q == CW'(TIMEOUT_CYCLES);
    assign cnt_d = (state_q != GRANT || bus.s_ack_i || bus.s_err_i) ? '0
                 : cnt_q + CW'(bus.m_stb_i[gidx_q]);
    always_ff @(posedge clk) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gidx_d      = gidx_q;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_tgd_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus.s_cyc_o             = bus.m_cyc_i[gidx_q];
                bus.s_stb_o             = bus.m_stb_i[gidx_q];
                bus.s_we_o              = bus.m_we_i[gidx_q];
                bus.s_sel_o             = bus.m_sel_i[4*gidx_q +: 4];
                bus.s_adr_o             = bus.m_adr_i[32*gidx_q +: 32];
                bus.s_dat_o             = bus.m_dat_i[32*gidx_q +: 32];
                bus.s_tgd_o             = bus.m_tgd_i[TAGSIZE*gidx_q +: TAGSIZE];
                bus.m_dat_o             = bus.s_dat_i;
                bus.m_ack_o[gidx_q]     = bus.s_ack_i & ~bus.s_err_i;
                bus.m_err_o[gidx_q]     = bus.s_err_i;
                if (!bus.m_cyc_i[gidx_q]) begin
                    last_d  = gidx_q;
                    state_d = IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (tmo) begin
                    bus.s_cyc_o         = 1'b0;
                    bus.s_stb_o         = 1'b0;
                    bus.m_ack_o         = '0;
                    bus.m_err_o         = '0;
                    bus.m_err_o[gidx_q] = 1'b1;
                    state_d             = ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!bus.m_cyc_i[gidx_q]) begin
                    last_d  = gidx_q;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            last_q  <= LW'(N_MASTER - 1);
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus randomized masters/slave checked against a round-robin ownership model.
module tb_wb_rr_arbiter;
    localparam int N  = 4;
    localparam int TG = 1;

    logic clk = 1'b0;
    logic rstn;
    logic chk_en = 1'b0;
    logic [N-1:0] grant;
    logic busy;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.N_MASTER(N), .TAGSIZE(TG)) bus ();

    wb_rr_arbiter #(.N_MASTER(N), .TAGSIZE(TG), .TIMEOUT_CYCLES(256)) dut (
        .clk(clk), .rstn_i(rstn), .bus(bus), .grant_o(grant), .busy_o(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: who owns the bus (-1 when idle) and who was served last.
    int owner = -1;
    int last  = N - 1;

    always @(negedge clk) begin
        logic [N-1:0] eg, ea, ee;
        logic [31:0]  ed;
        logic [71:0]  es;
        eg = '0; ea = '0; ee = '0; ed = '0; es = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ea[owner] = bus.s_ack_i & ~bus.s_err_i;
            ee[owner] = bus.s_err_i;
            ed        = bus.s_dat_i;
            es = {bus.m_cyc_i[owner], bus.m_stb_i[owner], bus.m_we_i[owner], bus.m_sel_i[4*owner +: 4],
                  bus.m_adr_i[32*owner +: 32], bus.m_dat_i[32*owner +: 32], bus.m_tgd_i[TG*owner +: TG]};
        end
        if (chk_en) begin
            check("grant", {grant, busy}, {eg, owner >= 0});
            check("slave", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o, bus.s_tgd_o}, es);
            check("resp", {bus.m_ack_o, bus.m_err_o, bus.m_dat_o}, {ea, ee, ed});
        end
        if (!rstn) begin
            owner = -1;
            last  = N - 1;
        end else if (owner < 0) begin
            for (int i = 1; i <= N; i++)
                if (owner < 0 && bus.m_cyc_i[(last + i) % N]) owner = (last + i) % N;
        end else if (!bus.m_cyc_i[owner]) begin
            last  = owner;
            owner = -1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0; bus.m_sel_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_tgd_i = '0;
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_dat_i = '0;
    endtask

    task automatic set_m(int k, logic we, logic [31:0] adr, logic [31:0] dat);
        bus.m_cyc_i[k] = 1'b1;
        bus.m_stb_i[k] = 1'b1;
        bus.m_we_i[k]  = we;
        bus.m_sel_i[4*k +: 4]   = 4'hF;
        bus.m_adr_i[32*k +: 32] = adr;
        bus.m_dat_i[32*k +: 32] = dat;
        bus.m_tgd_i[TG*k +: TG] = TG'(k);
    endtask

    task automatic drop_m(int k);
        bus.m_cyc_i[k] = 1'b0;
        bus.m_stb_i[k] = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // One single-beat transfer by master k, zero-wait ACK, then release and the dead cycle.
    task automatic serve(int k, bit rereq, string nm);
        logic [N-1:0] oh;
        oh = '0;
        oh[k] = 1'b1;
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hA5A5_0000 | k;
        @(negedge clk);
        check({nm, "_grant"}, grant, oh);
        check({nm, "_ack"}, bus.m_ack_o, oh);
        tick();
        bus.s_ack_i = 1'b0;
        drop_m(k);
        tick();
        if (rereq) set_m(k, 1'b1, 32'h10 * k, k);
        @(negedge clk);
        check({nm, "_dead"}, grant, '0);
    endtask

    bit act[N];
    int beats[N];
    logic [N-1:0] done;

    initial begin
        rstn = 1'b0;
        idle_all();
        tick();
        tick();
        rstn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_grant", {grant, busy}, '0);
        check("rst_out", {bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o}, '0);

        // single master 2 write
        tick();
        set_m(2, 1'b1, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_latency", bus.s_cyc_o, 1'b0);
        tick();
        @(negedge clk);
        check("t1_grant", grant, 4'b0100);
        check("t1_slave", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o},
              {1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF});
        tick();
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        check("t1_ack", bus.m_ack_o, 4'b0100);
        tick();
        bus.s_ack_i = 1'b0;
        drop_m(2);
        @(negedge clk);
        check("t1_hold", grant, 4'b0100);
        tick();
        @(negedge clk);
        check("t1_release", grant, '0);

        // simultaneous 0,1,3 after reset
        tick();
        do_reset();
        set_m(0, 1'b1, 32'h0, 32'h0);
        set_m(1, 1'b1, 32'h4, 32'h1);
        set_m(3, 1'b1, 32'hC, 32'h3);
        serve(0, 1'b0, "t2_m0");
        serve(1, 1'b0, "t2_m1");
        serve(3, 1'b0, "t2_m3");

        // master 1 back-to-back against waiting master 3
        tick();
        set_m(1, 1'b1, 32'h10, 32'h1);
        set_m(3, 1'b1, 32'h30, 32'h3);
        serve(1, 1'b1, "t3_a1");
        serve(3, 1'b1, "t3_a3");
        serve(1, 1'b1, "t3_b1");
        serve(3, 1'b0, "t3_b3");
        serve(1, 1'b0, "t3_c1");

        // master 0 four-beat block read while master 2 waits
        tick();
        set_m(0, 1'b0, 32'h40, 32'h0);
        tick();
        set_m(2, 1'b1, 32'h200, 32'h55);
        for (int b = 1; b <= 4; b++) begin
            bus.s_dat_i = 32'(b);
            bus.s_ack_i = 1'b1;
            @(negedge clk);
            check("t4_beat", {grant, bus.m_ack_o, bus.m_dat_o}, {4'b0001, 4'b0001, 32'(b)});
            tick();
            bus.s_ack_i = 1'b0;
            @(negedge clk);
            check("t4_held", grant, 4'b0001);
            tick();
        end
        drop_m(0);
        tick();
        @(negedge clk);
        check("t4_dead", grant, '0);
        tick();
        @(negedge clk);
        check("t4_m2", grant, 4'b0100);
        tick();
        drop_m(2);
        tick();
        tick();

        // reset during an ACK right after master 0 is granted
        set_m(0, 1'b1, 32'h80, 32'h8);
        tick();
        rstn = 1'b0;
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        check("t5_pre", bus.m_ack_o, 4'b0001);
        tick();
        @(negedge clk);
        check("t5_reset", {grant, busy, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o}, '0);
        tick();
        rstn = 1'b1;
        set_m(1, 1'b1, 32'h90, 32'h9);
        @(negedge clk);
        check("t5_ack_idle", {grant, bus.m_ack_o}, '0);
        tick();
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        check("t5_regrant", grant, 4'b0001);
        tick();
        idle_all();
        tick();
        tick();

        // randomized masters and slave
        for (int k = 0; k < N; k++) begin
            act[k]   = 1'b0;
            beats[k] = 0;
        end
        repeat (3000) begin
            @(negedge clk);
            done = bus.m_ack_o | bus.m_err_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (act[k] && done[k]) begin
                    beats[k]--;
                    if (beats[k] == 0) begin
                        drop_m(k);
                        act[k] = 1'b0;
                    end else begin
                        bus.m_adr_i[32*k +: 32] = $urandom;
                        bus.m_dat_i[32*k +: 32] = $urandom;
                    end
                end else if (!act[k] && $urandom_range(3) == 0) begin
                    set_m(k, 1'($urandom), $urandom, $urandom);
                    bus.m_sel_i[4*k +: 4]   = 4'($urandom);
                    bus.m_tgd_i[TG*k +: TG] = TG'($urandom);
                    beats[k] = $urandom_range(3, 1);
                    act[k]   = 1'b1;
                end
            end
            bus.s_ack_i = $urandom_range(2) == 0;
            bus.s_err_i = $urandom_range(7) == 0;
            bus.s_dat_i = $urandom;
            rstn = $urandom_range(499) != 0;
        end
        rstn = 1'b1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
